// File: rtl/dsp_fifo_pkg.sv
// Shared definitions for the DSP-side FIFOs: width helpers, default
// thresholds and the default {A,B} lane-pair entry layout.
package dsp_fifo_pkg;

  localparam int DEF_AWIDTH    = 18;
  localparam int DEF_BWIDTH    = 25;
  localparam int DEF_DEPTH     = 32;
  localparam int DEF_AE_THRESH = 4;
  // almost_full defaults to this many entries below DEPTH
  localparam int DEF_AF_MARGIN = 4;

  // Pointer width: enough bits to address every entry, never zero.
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Occupancy width: one extra bit so that count == DEPTH is representable.
  function automatic int count_width(input int depth);
    return ptr_width(depth) + 1;
  endfunction

  // Lane A sits in the upper bits, lane B in the lower bits of one entry.
  typedef struct packed {
    logic [DEF_AWIDTH-1:0] a;
    logic [DEF_BWIDTH-1:0] b;
  } entry_t;

endpackage

// File: rtl/sync_fifo_ext_if.sv
// Handshake and status bundle of the dual-lane FIFO. The producer/consumer
// side uses the master modport, the FIFO itself the slave modport.
interface sync_fifo_ext_if
  import dsp_fifo_pkg::*;
#(
  parameter int AWIDTH = DEF_AWIDTH,
  parameter int BWIDTH = DEF_BWIDTH,
  parameter int DEPTH  = DEF_DEPTH
);
  localparam int CW = count_width(DEPTH);

  logic              flush;
  logic              wr_en;
  logic              rd_en;
  logic [AWIDTH-1:0] a_in;
  logic [BWIDTH-1:0] b_in;
  logic [AWIDTH-1:0] a_out;
  logic [BWIDTH-1:0] b_out;
  logic              empty;
  logic              full;
  logic              almost_empty;
  logic              almost_full;
  logic [CW-1:0]     count;
  logic              overflow;
  logic              underflow;

  modport master (
    output flush, wr_en, rd_en, a_in, b_in,
    input  a_out, b_out, empty, full, almost_empty, almost_full,
           count, overflow, underflow
  );

  modport slave (
    input  flush, wr_en, rd_en, a_in, b_in,
    output a_out, b_out, empty, full, almost_empty, almost_full,
           count, overflow, underflow
  );

endinterface

// File: rtl/fifo_ram.sv
// Simple dual-port storage: one synchronous write port, one asynchronous
// read port. Contents are plain data and are never reset.
module fifo_ram
  import dsp_fifo_pkg::*;
#(
  parameter int WIDTH = DEF_AWIDTH + DEF_BWIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                        clk,
  input  logic                        we,
  input  logic [ptr_width(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]            wdata,
  input  logic [ptr_width(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]            rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Store the incoming entry at the write pointer
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_ext.sv
// Dual-lane synchronous FIFO between the DSP front end and the FIR chain.
// Registered count is the single source of truth; every status flag is a
// decode of it, so no request input reaches an output combinationally.
module sync_fifo_ext
  import dsp_fifo_pkg::*;
#(
  parameter int AWIDTH    = DEF_AWIDTH,
  parameter int BWIDTH    = DEF_BWIDTH,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int FWFT      = 0,
  parameter int AF_THRESH = DEPTH - DEF_AF_MARGIN,
  parameter int AE_THRESH = DEF_AE_THRESH
) (
  input  logic             clk,
  input  logic             rst,
  sync_fifo_ext_if.slave   bus
);

  localparam int PW = ptr_width(DEPTH);
  localparam int CW = count_width(DEPTH);
  localparam int EW = AWIDTH + BWIDTH;

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);

  // Parameter sanity, caught at elaboration
  if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_chk_depth
    $error("sync_fifo_ext: DEPTH must be a power of two and at least 4");
  end
  if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_chk_af
    $error("sync_fifo_ext: AF_THRESH must lie in 1..DEPTH");
  end
  if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_chk_ae
    $error("sync_fifo_ext: AE_THRESH must lie in 0..DEPTH-1");
  end
  if (FWFT != 0 && FWFT != 1) begin : g_chk_fwft
    $error("sync_fifo_ext: FWFT must be 0 or 1");
  end

  // Parameterised widths need a module-local copy of the lane-pair layout
  typedef struct packed {
    logic [AWIDTH-1:0] a;
    logic [BWIDTH-1:0] b;
  } lane_pair_t;

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count_r;
  logic          ovf_r;
  logic          unf_r;
  logic          empty_w;
  logic          full_w;
  logic          wr_acc;
  logic          rd_acc;
  lane_pair_t    wr_e;
  lane_pair_t    rd_e;
  logic [EW-1:0] rdata_w;

  assign empty_w = (count_r == '0);
  assign full_w  = (count_r == DEPTH_C);

  // Flush wins over both requests; a write on full is rejected even when a
  // read is accepted in the same cycle.
  assign wr_acc = bus.wr_en && !full_w  && !bus.flush;
  assign rd_acc = bus.rd_en && !empty_w && !bus.flush;

  assign wr_e.a = bus.a_in;
  assign wr_e.b = bus.b_in;
  assign rd_e   = rdata_w;

  fifo_ram #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wr_ptr),
    .wdata (wr_e),
    .raddr (rd_ptr),
    .rdata (rdata_w)
  );

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_r <= '0;
    end else if (bus.flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_r <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + PW'(1);
      if (rd_acc) rd_ptr <= rd_ptr + PW'(1);
      case ({wr_acc, rd_acc})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Sticky error flags, cleared only by reset or flush
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_r <= 1'b0;
      unf_r <= 1'b0;
    end else if (bus.flush) begin
      ovf_r <= 1'b0;
      unf_r <= 1'b0;
    end else begin
      if (bus.wr_en && full_w)  ovf_r <= 1'b1;
      if (bus.rd_en && empty_w) unf_r <= 1'b1;
    end
  end

  if (FWFT != 0) begin : g_fwft
    // Head of queue is always on the outputs; meaningless while empty
    assign bus.a_out = rd_e.a;
    assign bus.b_out = rd_e.b;
  end else begin : g_regd
    logic [AWIDTH-1:0] a_q;
    logic [BWIDTH-1:0] b_q;

    // Capture the head on an accepted read, hold otherwise (flush included)
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        a_q <= '0;
        b_q <= '0;
      end else if (rd_acc) begin
        a_q <= rd_e.a;
        b_q <= rd_e.b;
      end
    end

    assign bus.a_out = a_q;
    assign bus.b_out = b_q;
  end

  assign bus.count        = count_r;
  assign bus.empty        = empty_w;
  assign bus.full         = full_w;
  assign bus.almost_empty = (count_r <= AE_C);
  assign bus.almost_full  = (count_r >= AF_C);
  assign bus.overflow     = ovf_r;
  assign bus.underflow    = unf_r;

endmodule

// File: tb/tb_sync_fifo_ext.sv
// Bench for sync_fifo_ext: one registered-read and one FWFT instance driven
// with identical stimulus and compared every cycle against a queue model.
module tb_sync_fifo_ext;

  localparam int AW    = 18;
  localparam int BW    = 25;
  localparam int DEPTH = 32;
  localparam int AFT   = 28;
  localparam int AET   = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  sync_fifo_ext_if #(.AWIDTH(AW), .BWIDTH(BW), .DEPTH(DEPTH)) if0 ();
  sync_fifo_ext_if #(.AWIDTH(AW), .BWIDTH(BW), .DEPTH(DEPTH)) if1 ();

  sync_fifo_ext #(
    .AWIDTH(AW), .BWIDTH(BW), .DEPTH(DEPTH), .FWFT(0),
    .AF_THRESH(AFT), .AE_THRESH(AET)
  ) u_dut0 (
    .clk (clk),
    .rst (rst),
    .bus (if0)
  );

  sync_fifo_ext #(
    .AWIDTH(AW), .BWIDTH(BW), .DEPTH(DEPTH), .FWFT(1),
    .AF_THRESH(AFT), .AE_THRESH(AET)
  ) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (if1)
  );

  typedef struct {
    logic [AW-1:0] a;
    logic [BW-1:0] b;
  } ent_t;

  // Reference model: a queue of entries plus sticky flags and the last read
  ent_t          q[$];
  logic          m_ovf = 1'b0;
  logic          m_unf = 1'b0;
  logic [AW-1:0] m_a   = '0;
  logic [BW-1:0] m_b   = '0;

  int    checks   = 0;
  int    failures = 0;
  string phase    = "reset";

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s.%s: got %0h expected %0h at %0t", phase, tag, got, want, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    m_a   = '0;
    m_b   = '0;
  endtask

  task automatic model_step(input logic w, input logic r, input logic f,
                            input logic [AW-1:0] a, input logic [BW-1:0] b);
    bit was_full;
    bit was_empty;
    ent_t e;
    if (f) begin
      q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      was_full  = (q.size() == DEPTH);
      was_empty = (q.size() == 0);
      if (w && was_full)  m_ovf = 1'b1;
      if (r && was_empty) m_unf = 1'b1;
      if (r && !was_empty) begin
        e   = q.pop_front();
        m_a = e.a;
        m_b = e.b;
      end
      if (w && !was_full) begin
        e.a = a;
        e.b = b;
        q.push_back(e);
      end
    end
  endtask

  task automatic check_all();
    int n;
    n = q.size();
    chk("count0", 64'(if0.count), 64'(n));
    chk("count1", 64'(if1.count), 64'(n));
    chk("empty0", 64'(if0.empty), 64'(n == 0));
    chk("empty1", 64'(if1.empty), 64'(n == 0));
    chk("full0",  64'(if0.full),  64'(n == DEPTH));
    chk("full1",  64'(if1.full),  64'(n == DEPTH));
    chk("aempty0", 64'(if0.almost_empty), 64'(n <= AET));
    chk("afull0",  64'(if0.almost_full),  64'(n >= AFT));
    chk("aempty1", 64'(if1.almost_empty), 64'(n <= AET));
    chk("afull1",  64'(if1.almost_full),  64'(n >= AFT));
    chk("ovf0", 64'(if0.overflow),  64'(m_ovf));
    chk("unf0", 64'(if0.underflow), 64'(m_unf));
    chk("ovf1", 64'(if1.overflow),  64'(m_ovf));
    chk("unf1", 64'(if1.underflow), 64'(m_unf));
    chk("a_out0", 64'(if0.a_out), 64'(m_a));
    chk("b_out0", 64'(if0.b_out), 64'(m_b));
    if (n > 0) begin
      chk("a_out1", 64'(if1.a_out), 64'(q[0].a));
      chk("b_out1", 64'(if1.b_out), 64'(q[0].b));
    end
  endtask

  task automatic drive(input logic w, input logic r, input logic f,
                       input logic [AW-1:0] a, input logic [BW-1:0] b);
    if0.wr_en = w; if1.wr_en = w;
    if0.rd_en = r; if1.rd_en = r;
    if0.flush = f; if1.flush = f;
    if0.a_in  = a; if1.a_in  = a;
    if0.b_in  = b; if1.b_in  = b;
  endtask

  // One clock: apply request, let the edge happen, update model, compare
  task automatic step(input logic w, input logic r, input logic f,
                      input logic [AW-1:0] a, input logic [BW-1:0] b);
    drive(w, r, f, a, b);
    @(posedge clk);
    model_step(w, r, f, a, b);
    #1;
    check_all();
  endtask

  task automatic rand_step(input int wpct, input int rpct);
    logic w, r, f;
    w = ($urandom_range(99) < wpct);
    r = ($urandom_range(99) < rpct);
    f = ($urandom_range(59) == 0);
    step(w, r, f, AW'($urandom), BW'($urandom));
  endtask

  initial begin
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    model_reset();
    #7;
    check_all();
    #1 rst = 1'b0;

    phase = "fill";
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 1'b0, AW'(i), BW'(32'h100000 + i));
    chk("full_after_32", 64'(if0.full), 64'd1);

    phase = "overflow";
    step(1'b1, 1'b0, 1'b0, AW'(18'h3FFFF), BW'(25'h1ABCDEF));
    chk("ovf_set", 64'(if0.overflow), 64'd1);
    step(1'b0, 1'b0, 1'b0, '0, '0);

    phase = "drain";
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 1'b0, '0, '0);
    chk("last_a", 64'(if0.a_out), 64'd31);
    chk("empty_after_drain", 64'(if0.empty), 64'd1);

    phase = "underflow";
    step(1'b0, 1'b1, 1'b0, '0, '0);
    chk("unf_set", 64'(if0.underflow), 64'd1);
    step(1'b0, 1'b0, 1'b1, '0, '0);
    chk("flush_ovf", 64'(if0.overflow), 64'd0);
    chk("flush_unf", 64'(if0.underflow), 64'd0);

    phase = "mixed40";
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0, AW'($urandom), BW'($urandom));
    for (int i = 0; i < 40; i++) rand_step(55, 45);

    phase = "wrap";
    step(1'b0, 1'b0, 1'b1, '0, '0);
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 1'b0, AW'($urandom), BW'($urandom));
    for (int i = 0; i < 100; i++) step(1'b1, 1'b1, 1'b0, AW'($urandom), BW'($urandom));
    chk("wrap_count", 64'(if0.count), 64'd16);

    phase = "full_rw";
    while (q.size() < DEPTH) step(1'b1, 1'b0, 1'b0, AW'($urandom), BW'($urandom));
    step(1'b1, 1'b1, 1'b0, AW'($urandom), BW'($urandom));
    chk("full_rw_count", 64'(if0.count), 64'd31);
    chk("full_rw_ovf", 64'(if0.overflow), 64'd1);

    phase = "fwft";
    step(1'b0, 1'b0, 1'b1, '0, '0);
    step(1'b1, 1'b0, 1'b0, AW'(18'h2A5), BW'(25'h0000123));
    chk("fwft_empty", 64'(if1.empty), 64'd0);
    chk("fwft_head", 64'(if1.a_out), 64'h2A5);
    step(1'b1, 1'b0, 1'b0, AW'(18'h155), BW'(25'h0000456));
    step(1'b0, 1'b1, 1'b0, '0, '0);
    chk("fwft_next", 64'(if1.a_out), 64'h155);

    phase = "async_rst";
    step(1'b0, 1'b0, 1'b1, '0, '0);
    for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 1'b0, AW'($urandom), BW'($urandom));
    step(1'b1, 1'b1, 1'b0, AW'($urandom), BW'($urandom));
    chk("pre_rst_count", 64'(if0.count), 64'd12);
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    #2 rst = 1'b1;
    model_reset();
    #1;
    check_all();
    #2 rst = 1'b0;

    phase = "flush_wr";
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 1'b0, AW'($urandom), BW'($urandom));
    step(1'b1, 1'b0, 1'b1, AW'($urandom), BW'($urandom));
    chk("flush_wr_count", 64'(if0.count), 64'd0);

    phase = "random";
    for (int i = 0; i < 150; i++) rand_step(70, 30);
    for (int i = 0; i < 150; i++) rand_step(30, 70);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard stop in case a clocking wait ever stalls
  initial begin
    #200000;
    $display("FAIL timeout: got no completion expected completion");
    $fatal(1, "timeout");
  end

endmodule
